// File: rtl/sie_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// sie_phase_sequencer_if
// Bundles the tick strobe, ignition request, per-phase durations and the
// published sequencer state of one Schumann Ignition Event engine.
//   master : drives clk_en, ignite_req and the six durations; observes outputs
//   slave  : the sequencer itself
// Signals:
//   clk_en            4 kHz update strobe
//   ignite_req        level request to start an event
//   sie_phase2_dur..sie_phase6_dur, sie_refractory  phase lengths in ticks
//   sie_phase         current phase code (0,2..7)
//   phase_count       ticks elapsed in the current phase
//   sie_active        high in phases 2..6
//   sie_in_refractory high in REFRACTORY
//   phase_start       one-clk pulse on every phase entry
//   event_done        one-clk pulse on DECAY -> REFRACTORY
//   ignite_reject     one-clk pulse for a request seen outside IDLE
//   envelope          signed Q14 ignition gain
// ---------------------------------------------------------------------------
interface sie_phase_sequencer_if #(
    parameter int WIDTH = 18
);
    logic                    clk_en;
    logic                    ignite_req;
    logic [15:0]             sie_phase2_dur;
    logic [15:0]             sie_phase3_dur;
    logic [15:0]             sie_phase4_dur;
    logic [15:0]             sie_phase5_dur;
    logic [15:0]             sie_phase6_dur;
    logic [15:0]             sie_refractory;
    logic [2:0]              sie_phase;
    logic [15:0]             phase_count;
    logic                    sie_active;
    logic                    sie_in_refractory;
    logic                    phase_start;
    logic                    event_done;
    logic                    ignite_reject;
    logic signed [WIDTH-1:0] envelope;

    modport master (
        output clk_en, ignite_req,
        output sie_phase2_dur, sie_phase3_dur, sie_phase4_dur,
        output sie_phase5_dur, sie_phase6_dur, sie_refractory,
        input  sie_phase, phase_count, sie_active, sie_in_refractory,
        input  phase_start, event_done, ignite_reject, envelope
    );

    modport slave (
        input  clk_en, ignite_req,
        input  sie_phase2_dur, sie_phase3_dur, sie_phase4_dur,
        input  sie_phase5_dur, sie_phase6_dur, sie_refractory,
        output sie_phase, phase_count, sie_active, sie_in_refractory,
        output phase_start, event_done, ignite_reject, envelope
    );
endinterface

// File: rtl/sie_phase_sequencer.sv
// ---------------------------------------------------------------------------
// sie_phase_sequencer
// Steps one Schumann Ignition Event through COHERENCE, IGNITION, PLATEAU,
// PROPAGATION, DECAY and REFRACTORY on clk_en ticks, publishing the phase,
// a per-phase tick counter and a saturating Q14 ignition envelope.
// Ports:
//   clk  : single clock
//   rst  : asynchronous active-high reset
//   bus  : sie_phase_sequencer_if.slave (strobe, request, durations, outputs)
// Parameters:
//   WIDTH    envelope word width (signed Q14)
//   ENV_MAX  envelope ceiling (1.0 in Q14)
//   ENV_STEP envelope increment/decrement per tick
// ---------------------------------------------------------------------------
module sie_phase_sequencer #(
    parameter int WIDTH    = 18,
    parameter int ENV_MAX  = 16384,
    parameter int ENV_STEP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sie_phase_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COHERENCE   = 3'd2,
        ST_IGNITION    = 3'd3,
        ST_PLATEAU     = 3'd4,
        ST_PROPAGATION = 3'd5,
        ST_DECAY       = 3'd6,
        ST_REFRACTORY  = 3'd7
    } phase_e;

    localparam logic signed [WIDTH:0]   ENV_MAX_X  = (WIDTH+1)'(ENV_MAX);
    localparam logic signed [WIDTH:0]   ENV_STEP_X = (WIDTH+1)'(ENV_STEP);
    localparam logic signed [WIDTH:0]   ENV_ZERO_X = {(WIDTH+1){1'b0}};
    localparam logic signed [WIDTH-1:0] ENV_MAX_W  = WIDTH'(ENV_MAX);
    localparam logic signed [WIDTH-1:0] ENV_ZERO_W = {WIDTH{1'b0}};

    // Index 0 = COHERENCE ... index 5 = REFRACTORY; reset holds NORMAL defaults.
    localparam logic [5:0][15:0] SNAP_RESET = {16'd40000, 16'd16000, 16'd36000,
                                               16'd10000, 16'd10000, 16'd14000};

    // Clamp a one-bit-wider envelope result into [0, ENV_MAX].
    function automatic logic signed [WIDTH-1:0] env_clamp(input logic signed [WIDTH:0] v);
        if (v > ENV_MAX_X) begin
            return ENV_MAX_W;
        end else if (v < ENV_ZERO_X) begin
            return ENV_ZERO_W;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Successor in the fixed event order; REFRACTORY wraps to IDLE.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            ST_COHERENCE:   return ST_IGNITION;
            ST_IGNITION:    return ST_PLATEAU;
            ST_PLATEAU:     return ST_PROPAGATION;
            ST_PROPAGATION: return ST_DECAY;
            ST_DECAY:       return ST_REFRACTORY;
            default:        return ST_IDLE;
        endcase
    endfunction

    phase_e                  phase_r, phase_s;
    logic [15:0]             count_r, count_s;
    logic signed [WIDTH-1:0] env_r, env_s;
    logic [5:0][15:0]        snap_r, snap_s;
    logic                    phase_start_r, phase_start_s;
    logic                    event_done_r, event_done_s;
    logic                    ignite_reject_r, ignite_reject_s;

    logic [15:0]             dur_s;
    logic [15:0]             dur_eff_s;
    logic                    last_tick_s;
    logic signed [WIDTH:0]   env_ext_s;

    assign env_ext_s = {env_r[WIDTH-1], env_r};

    // Frozen duration of the current phase; a zero duration still lasts one tick.
    always_comb begin
        dur_s = 16'd1;
        case (phase_r)
            ST_COHERENCE:   dur_s = snap_r[0];
            ST_IGNITION:    dur_s = snap_r[1];
            ST_PLATEAU:     dur_s = snap_r[2];
            ST_PROPAGATION: dur_s = snap_r[3];
            ST_DECAY:       dur_s = snap_r[4];
            ST_REFRACTORY:  dur_s = snap_r[5];
            default:        dur_s = 16'd1;
        endcase
        if (dur_s == 16'd0) begin
            dur_eff_s = 16'd1;
        end else begin
            dur_eff_s = dur_s;
        end
        last_tick_s = (count_r == (dur_eff_s - 16'd1));
    end

    // Next-state, counter, envelope, snapshot and pulse decisions for one tick.
    always_comb begin
        phase_s         = phase_r;
        count_s         = count_r;
        env_s           = env_r;
        snap_s          = snap_r;
        phase_start_s   = 1'b0;
        event_done_s    = 1'b0;
        ignite_reject_s = 1'b0;
        if (bus.clk_en) begin
            // Envelope follows the phase that is active during this tick.
            case (phase_r)
                ST_IGNITION:                env_s = env_clamp(env_ext_s + ENV_STEP_X);
                ST_PLATEAU, ST_PROPAGATION: env_s = ENV_MAX_W;
                ST_DECAY:                   env_s = env_clamp(env_ext_s - ENV_STEP_X);
                default:                    env_s = ENV_ZERO_W;
            endcase
            if (phase_r == ST_IDLE) begin
                count_s = 16'd0;
                if (bus.ignite_req) begin
                    snap_s        = {bus.sie_refractory, bus.sie_phase6_dur,
                                     bus.sie_phase5_dur, bus.sie_phase4_dur,
                                     bus.sie_phase3_dur, bus.sie_phase2_dur};
                    phase_s       = ST_COHERENCE;
                    phase_start_s = 1'b1;
                end else begin
                    phase_s = ST_IDLE;
                end
            end else begin
                ignite_reject_s = bus.ignite_req;
                if (last_tick_s) begin
                    phase_s       = next_phase(phase_r);
                    count_s       = 16'd0;
                    phase_start_s = 1'b1;
                    event_done_s  = (phase_r == ST_DECAY);
                end else begin
                    count_s = count_r + 16'd1;
                end
            end
        end else begin
            phase_s = phase_r;
        end
    end

    // State and output registers with asynchronous reset to the idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r         <= ST_IDLE;
            count_r         <= 16'd0;
            env_r           <= ENV_ZERO_W;
            snap_r          <= SNAP_RESET;
            phase_start_r   <= 1'b0;
            event_done_r    <= 1'b0;
            ignite_reject_r <= 1'b0;
        end else begin
            phase_r         <= phase_s;
            count_r         <= count_s;
            env_r           <= env_s;
            snap_r          <= snap_s;
            phase_start_r   <= phase_start_s;
            event_done_r    <= event_done_s;
            ignite_reject_r <= ignite_reject_s;
        end
    end

    assign bus.sie_phase         = phase_r;
    assign bus.phase_count       = count_r;
    assign bus.envelope          = env_r;
    assign bus.phase_start       = phase_start_r;
    assign bus.event_done        = event_done_r;
    assign bus.ignite_reject     = ignite_reject_r;
    assign bus.sie_active        = (phase_r != ST_IDLE) && (phase_r != ST_REFRACTORY);
    assign bus.sie_in_refractory = (phase_r == ST_REFRACTORY);

endmodule

// File: tb/tb_sie_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sie_phase_sequencer
// Directed and randomized stimulus for sie_phase_sequencer. Expected values
// come from an event-timeline model: the position inside an event is derived
// from the tick offset since the start tick and the cumulative phase lengths,
// and the envelope from closed-form ramp arithmetic.
// ---------------------------------------------------------------------------
module tb_sie_phase_sequencer;
    localparam int WIDTH    = 18;
    localparam int ENV_MAX  = 16384;
    localparam int ENV_STEP = 8000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sie_phase_sequencer_if #(.WIDTH(WIDTH)) bus();

    sie_phase_sequencer #(.WIDTH(WIDTH), .ENV_MAX(ENV_MAX), .ENV_STEP(ENV_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    tests = 0;
    int    fails = 0;
    string scen  = "init";

    logic [15:0] d    [6];   // durations currently driven
    logic [15:0] snap [6];   // durations the model froze at event start
    bit          in_ev = 1'b0;
    int          k     = 0;  // ticks since the start tick of the running event
    int          exp_ph = 0, exp_cnt = 0, exp_env = 0;
    int          n_start, n_done, n_rej;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%0d expected=%0d", scen, tag, obs, exp);
        end
    endtask

    task automatic drive_durs();
        bus.sie_phase2_dur = d[0];
        bus.sie_phase3_dur = d[1];
        bus.sie_phase4_dur = d[2];
        bus.sie_phase5_dur = d[3];
        bus.sie_phase6_dur = d[4];
        bus.sie_refractory = d[5];
    endtask

    function automatic int plen(input int i);
        return (snap[i] == 16'd0) ? 1 : int'(snap[i]);
    endfunction

    function automatic int total_len();
        int s = 0;
        for (int i = 0; i < 6; i++) s += plen(i);
        return s;
    endfunction

    // Phase code and in-phase count after the tick with offset kk.
    function automatic void locate(input int kk, output int ph, output int cnt);
        int c = 0;
        ph  = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (kk < c + plen(i)) begin
                ph  = (i == 5) ? 7 : 2 + i;
                cnt = kk - c;
                return;
            end
            c += plen(i);
        end
    endfunction

    // Envelope after tick kk: ramps are anchored at 0 (after COHERENCE) and
    // at ENV_MAX (after PLATEAU/PROPAGATION), so j-th tick values are closed form.
    function automatic int env_after(input int kk);
        int ph, cnt, j;
        if (kk == 0) return 0;
        locate(kk - 1, ph, cnt);
        j = cnt + 1;
        case (ph)
            3:       return (j * ENV_STEP > ENV_MAX) ? ENV_MAX : j * ENV_STEP;
            4, 5:    return ENV_MAX;
            6:       return (ENV_MAX - j * ENV_STEP < 0) ? 0 : ENV_MAX - j * ENV_STEP;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs(input int ph, input int cnt, input int env,
                                 input bit st, input bit dn, input bit rj);
        check("phase",       bus.sie_phase, ph);
        check("phase_count", bus.phase_count, cnt);
        check("envelope",    $signed(bus.envelope), env);
        check("active",      bus.sie_active, (ph >= 2 && ph <= 6) ? 1 : 0);
        check("refractory",  bus.sie_in_refractory, (ph == 7) ? 1 : 0);
        check("phase_start", bus.phase_start, st);
        check("event_done",  bus.event_done, dn);
        check("reject",      bus.ignite_reject, rj);
    endtask

    // One clk cycle: apply strobe/request, then compare against the model.
    task automatic cycle(input bit en, input bit req);
        bit st, dn, rj;
        bus.clk_en     = en;
        bus.ignite_req = req;
        @(posedge clk);
        #1;
        if (bus.phase_start)   n_start++;
        if (bus.event_done)    n_done++;
        if (bus.ignite_reject) n_rej++;
        if (!en) begin
            check_outputs(exp_ph, exp_cnt, exp_env, 1'b0, 1'b0, 1'b0);
            return;
        end
        rj = req && (exp_ph != 0);
        if (!in_ev) begin
            if (req) begin
                snap  = d;
                in_ev = 1'b1;
                k     = 0;
            end
        end else begin
            k++;
        end
        if (in_ev) begin
            locate(k, exp_ph, exp_cnt);
            exp_env = env_after(k);
            st = (exp_cnt == 0);
            dn = (k == total_len() - plen(5));
            if (k >= total_len()) in_ev = 1'b0;
        end else begin
            exp_ph = 0; exp_cnt = 0; exp_env = 0; st = 1'b0; dn = 1'b0;
        end
        check_outputs(exp_ph, exp_cnt, exp_env, st, dn, rj);
    endtask

    initial begin
        int n, n_prop;
        bit hit;
        rst = 1'b1;
        bus.clk_en = 1'b0;
        bus.ignite_req = 1'b0;
        d = '{16'd4, 16'd3, 16'd2, 16'd5, 16'd3, 16'd6};
        drive_durs();

        // Reset state
        scen = "reset";
        @(posedge clk);
        #1;
        check_outputs(0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0);

        // Nominal event, strobe every 4th clk
        scen = "nominal";
        n_start = 0; n_done = 0;
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1);
        for (int t = 0; t < 30; t++) begin
            cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
        end
        check("start_count", n_start, 7);
        check("done_count", n_done, 1);

        // Envelope saturation with continuous strobe
        scen = "envelope";
        d = '{16'd2, 16'd4, 16'd1, 16'd1, 16'd3, 16'd2};
        drive_durs();
        cycle(1'b1, 1'b1);
        for (int t = 0; t < 16; t++) cycle(1'b1, 1'b0);

        // All-zero durations: one tick per phase
        scen = "zero";
        d = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        drive_durs();
        cycle(1'b1, 1'b1);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, 1'b0);
            n++;
            if (bus.sie_phase == 3'd0) break;
        end
        check("event_len", n, 6);

        // Snapshot: PROPAGATION length frozen at start
        scen = "snapshot";
        d = '{16'd3, 16'd1, 16'd1, 16'd10, 16'd1, 16'd1};
        drive_durs();
        cycle(1'b1, 1'b1);
        d[3] = 16'd2;
        drive_durs();
        n_prop = 0;
        for (int t = 0; t < 24; t++) begin
            cycle(1'b1, 1'b0);
            if (bus.sie_phase == 3'd5) n_prop++;
        end
        check("prop_len", n_prop, 10);

        // Held request: rejects during the event, retrigger after refractory
        scen = "retrigger";
        d = '{16'd2, 16'd1, 16'd1, 16'd2, 16'd1, 16'd6};
        drive_durs();
        cycle(1'b1, 1'b1);
        n_rej = 0;
        for (int t = 0; t < 14; t++) cycle(1'b1, 1'b1);
        check("reject_count", n_rej, 13);
        check("restart_phase", bus.sie_phase, 2);
        for (int t = 0; t < 20; t++) cycle(1'b1, 1'b0);

        // Randomized strobe, requests and duration changes
        scen = "random";
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 6; i++) d[i] = 16'($urandom_range(0, 5));
                drive_durs();
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
        end

        // Asynchronous reset in the middle of PLATEAU
        scen = "async_reset";
        for (int t = 0; t < 80 && in_ev; t++) cycle(1'b1, 1'b0);
        d = '{16'd3, 16'd2, 16'd5, 16'd4, 16'd2, 16'd3};
        drive_durs();
        cycle(1'b1, 1'b1);
        hit = 1'b0;
        for (int t = 0; t < 30; t++) begin
            cycle(1'b1, 1'b0);
            if (exp_ph == 4 && exp_cnt == 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("plateau_reached", hit, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs(0, 0, 0, 1'b0, 1'b0, 1'b0);
        in_ev = 1'b0; exp_ph = 0; exp_cnt = 0; exp_env = 0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            check("rst_phase", bus.sie_phase, 0);
            check("rst_done", bus.event_done, 0);
        end
        rst = 1'b0;
        for (int t = 0; t < 4; t++) cycle(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
